// File: rtl/lfsr_sync_checker_if.sv
// ============================================================================
// Module      : lfsr_sync_checker_if
// Description : Receive-side word stream (valid + data) into lfsr_sync_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_sync_checker_if #(
  parameter int WIDTH = 32
) ();
  logic             dv_in;
  logic [WIDTH-1:0] datain;

  modport master (output dv_in, output datain);
  modport slave  (input  dv_in, input  datain);
endinterface

`default_nettype wire

// File: rtl/lfsr_sync_checker.sv
// ============================================================================
// Module      : lfsr_sync_checker
// Description : Self-synchronising LFSR stream checker; seeds from received
//               words, then flywheels. Optional stats (word_count, lock_loss)
//               are enabled by defining LFSR_CHK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_sync_checker #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] POLY       = 32'h80200003,
  parameter int               LOCK_COUNT = 8,
  parameter int               LOSS_COUNT = 4,
  parameter int               CNT_W      = 16
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             err_clear,
  lfsr_sync_checker_if.slave    rx,
  output logic                  locked,
  output logic                  error,
  output logic [CNT_W-1:0]      err_count
`ifdef LFSR_CHK_STATS_EN
  ,
  output logic [47:0]           word_count,
  output logic [7:0]            lock_loss
`endif
);

  localparam int MCW = $clog2(LOCK_COUNT + 1);
  localparam int SCW = $clog2(LOSS_COUNT + 1);
  localparam logic [MCW-1:0] LOCK_CNT = MCW'(LOCK_COUNT);
  localparam logic [SCW-1:0] LOSS_CNT = SCW'(LOSS_COUNT);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [MCW-1:0]   match_cnt_q, match_cnt_d;
  logic [SCW-1:0]   miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
`ifdef LFSR_CHK_STATS_EN
  logic [47:0]      word_count_q, word_count_d;
  logic [7:0]       lock_loss_q, lock_loss_d;
`endif

  logic [WIDTH-1:0] expected;
  logic             is_match;

  assign expected = {prev_q[WIDTH-2:0], ^(prev_q & POLY)};
  // The all-zero word is the LFSR lock-up state, so it can never count as a match.
  assign is_match = (rx.datain == expected) && (rx.datain != '0);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    error_d     = error_q;
    err_count_d = err_count_q;
`ifdef LFSR_CHK_STATS_EN
    word_count_d = word_count_q;
    lock_loss_d  = lock_loss_q;
`endif
    if (rx.dv_in) begin
      case (state_q)
        SEARCH: begin
          prev_d = rx.datain;
          if (!have_prev_q) begin
            have_prev_d = 1'b1;
          end else if (is_match) begin
            match_cnt_d = match_cnt_q + MCW'(1);
            if (match_cnt_d == LOCK_CNT) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        default: begin
          // Flywheel: advance from our own prediction so one bad word is one error.
          prev_d = expected;
`ifdef LFSR_CHK_STATS_EN
          word_count_d = word_count_q + 48'd1;
`endif
          if (is_match) begin
            miss_cnt_d = '0;
          end else begin
            error_d    = 1'b1;
            miss_cnt_d = miss_cnt_q + SCW'(1);
            if (!(&err_count_q)) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            if (miss_cnt_d == LOSS_CNT) begin
              state_d     = SEARCH;
              locked_d    = 1'b0;
              have_prev_d = 1'b0;
              match_cnt_d = '0;
`ifdef LFSR_CHK_STATS_EN
              if (!(&lock_loss_q)) begin
                lock_loss_d = lock_loss_q + 8'd1;
              end
`endif
            end
          end
        end
      endcase
    end
    if (err_clear) begin
      error_d     = 1'b0;
      err_count_d = '0;
`ifdef LFSR_CHK_STATS_EN
      word_count_d = '0;
      lock_loss_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEARCH;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
`ifdef LFSR_CHK_STATS_EN
      word_count_q <= '0;
      lock_loss_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
`ifdef LFSR_CHK_STATS_EN
      word_count_q <= word_count_d;
      lock_loss_q  <= lock_loss_d;
`endif
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;
`ifdef LFSR_CHK_STATS_EN
  assign word_count = word_count_q;
  assign lock_loss  = lock_loss_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_sync_checker.sv
// Self-checking bench for lfsr_sync_checker: directed scenarios plus a
// randomized stream compared against a sequence-level reference model.
`default_nettype none

module tb_lfsr_sync_checker;

  localparam int          WIDTH = 32;
  localparam logic [31:0] POLY  = 32'h80200003;
  localparam int          LOCK  = 8;
  localparam int          LOSS  = 4;
  localparam int          CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic err_clear;
  logic clr2;

  lfsr_sync_checker_if #(.WIDTH(WIDTH)) bus  ();
  lfsr_sync_checker_if #(.WIDTH(WIDTH)) bus2 ();

  logic             locked, error;
  logic [CNT_W-1:0] err_count;
  logic             locked2, error2;
  logic [3:0]       err_count2;
`ifdef LFSR_CHK_STATS_EN
  logic [47:0] word_count, word_count2;
  logic [7:0]  lock_loss, lock_loss2;
`endif

  lfsr_sync_checker #(
    .WIDTH(WIDTH), .POLY(POLY), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .err_clear(err_clear), .rx(bus),
    .locked(locked), .error(error), .err_count(err_count)
`ifdef LFSR_CHK_STATS_EN
    , .word_count(word_count), .lock_loss(lock_loss)
`endif
  );

  lfsr_sync_checker #(
    .WIDTH(WIDTH), .POLY(POLY), .LOCK_COUNT(8), .LOSS_COUNT(32), .CNT_W(4)
  ) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .err_clear(clr2), .rx(bus2),
    .locked(locked2), .error(error2), .err_count(err_count2)
`ifdef LFSR_CHK_STATS_EN
    , .word_count(word_count2), .lock_loss(lock_loss2)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: tracks the stream at the "words seen" level.
  bit          m_locked, m_have, m_err;
  logic [31:0] m_prev;
  int          m_run, m_miss;
  logic [15:0] m_cnt;
  logic [47:0] m_words;
  logic [7:0]  m_losses;

  logic [31:0] g;   // transmit-side generator state
  logic [31:0] g2;

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], ^(s & POLY)};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_err = 0; m_prev = '0;
    m_run = 0; m_miss = 0; m_cnt = '0; m_words = '0; m_losses = '0;
  endtask

  task automatic model_step(input bit dv, input logic [31:0] d, input bit clr);
    logic [31:0] exp_w;
    bit          good;
    exp_w = nxt(m_prev);
    good  = (d == exp_w) && (d != 32'd0);
    if (dv) begin
      if (!m_locked) begin
        if (m_have) begin
          m_run = good ? m_run + 1 : 0;
          if (m_run == LOCK) begin m_locked = 1; m_miss = 0; end
        end
        m_have = 1;
        m_prev = d;
      end else begin
        m_words = m_words + 1;
        m_prev  = exp_w;
        if (good) m_miss = 0;
        else begin
          m_miss = m_miss + 1;
          m_err  = 1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
          if (m_miss == LOSS) begin
            m_locked = 0; m_have = 0; m_run = 0;
            if (m_losses != 8'hFF) m_losses = m_losses + 1;
          end
        end
      end
    end
    if (clr) begin
      m_err = 0; m_cnt = '0; m_words = '0; m_losses = '0;
    end
  endtask

  task automatic step(input bit dv, input logic [31:0] d, input bit clr);
    bus.dv_in = dv; bus.datain = d; err_clear = clr;
    @(posedge clk);
    model_step(dv, d, clr);
    #1;
    bus.dv_in = 1'b0; err_clear = 1'b0;
  endtask

  task automatic clean(input int n);
    repeat (n) begin step(1'b1, g, 1'b0); g = nxt(g); end
  endtask

  task automatic corrupt(input logic [31:0] mask);
    step(1'b1, g ^ mask, 1'b0); g = nxt(g);
  endtask

  task automatic step2(input bit dv, input logic [31:0] d);
    bus2.dv_in = dv; bus2.datain = d;
    @(posedge clk); #1;
    bus2.dv_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; err_clear = 1'b0; clr2 = 1'b0;
    bus.dv_in = 1'b0; bus.datain = '0; bus2.dv_in = 1'b0; bus2.datain = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked got=%b exp=0", locked); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got=%b exp=0", error); end
    tests_run++; if (err_count !== '0) begin tests_failed++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    @(negedge clk); reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_clean_lock();
    g = 32'h1;
    clean(LOCK);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL lock_early got=%b exp=0", locked); end
    clean(1);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL lock_word9 got=%b exp=1", locked); end
    for (int i = 0; i < 10000; i++) begin
      clean(1);
      tests_run++;
      if (locked !== 1'b1 || error !== 1'b0 || err_count !== '0) begin
        tests_failed++;
        $display("FAIL clean_stream word=%0d got locked=%b error=%b cnt=%0d exp 1/0/0", i, locked, error, err_count);
      end
    end
  endtask

  task automatic test_single_error();
    corrupt(32'h0000_0100);
    clean(3);
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL single_err_error got=%b exp=1", error); end
    tests_run++; if (err_count !== 16'd1) begin tests_failed++; $display("FAIL single_err_count got=%0d exp=1", err_count); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL single_err_locked got=%b exp=1", locked); end
    step(1'b0, '0, 1'b1);
    tests_run++; if (error !== 1'b0 || err_count !== '0) begin tests_failed++; $display("FAIL clear_idle got error=%b cnt=%0d exp 0/0", error, err_count); end
  endtask

  task automatic test_loss();
    repeat (LOSS - 1) corrupt($urandom | 32'h1);
    tests_run++; if (locked !== 1'b1 || err_count !== 16'd3) begin tests_failed++; $display("FAIL loss_pre got locked=%b cnt=%0d exp 1/3", locked, err_count); end
    corrupt($urandom | 32'h1);
    tests_run++; if (locked !== 1'b0 || err_count !== 16'd4) begin tests_failed++; $display("FAIL loss_drop got locked=%b cnt=%0d exp 0/4", locked, err_count); end
`ifdef LFSR_CHK_STATS_EN
    tests_run++; if (lock_loss !== 8'd1) begin tests_failed++; $display("FAIL lock_loss got=%0d exp=1", lock_loss); end
`endif
    clean(LOCK);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL relock_early got=%b exp=0", locked); end
    clean(1);
    tests_run++; if (locked !== 1'b1 || err_count !== 16'd4) begin tests_failed++; $display("FAIL relock got locked=%b cnt=%0d exp 1/4", locked, err_count); end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_zero_words();
    do_reset();
    repeat (20) step(1'b1, 32'd0, 1'b0);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL zero_stream_locked got=%b exp=0", locked); end
  endtask

  task automatic test_gaps();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int nvalid = 0;
    int k = 0;
    do_reset();
    g = $urandom | 32'h1;
    while (nvalid < LOCK + 1) begin
      if (pat[k % 4]) begin clean(1); nvalid++; end
      else step(1'b0, $urandom, 1'b0);
      k++;
      if (nvalid < LOCK + 1) begin
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL gaps_early valid=%0d got=%b exp=0", nvalid, locked); end
      end
    end
    tests_run++; if (locked !== 1'b1 || error !== 1'b0) begin tests_failed++; $display("FAIL gaps_lock got locked=%b error=%b exp 1/0", locked, error); end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) != 0) clean(1); else step(1'b0, $urandom, 1'b0);
    end
    tests_run++; if (locked !== 1'b1 || error !== 1'b0 || err_count !== '0) begin tests_failed++; $display("FAIL gaps_run got locked=%b error=%b cnt=%0d exp 1/0/0", locked, error, err_count); end
  endtask

  task automatic test_err_clear_collision();
    corrupt(32'h8000_0000);
    tests_run++; if (err_count !== 16'd1) begin tests_failed++; $display("FAIL collide_pre got=%0d exp=1", err_count); end
    step(1'b1, g ^ 32'h0000_0010, 1'b1); g = nxt(g);
    tests_run++; if (error !== 1'b0 || err_count !== '0) begin tests_failed++; $display("FAIL collide_clear got error=%b cnt=%0d exp 0/0", error, err_count); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL collide_locked got=%b exp=1", locked); end
    clean(2);
  endtask

  task automatic test_saturation();
    g2 = $urandom | 32'h1;
    repeat (9) begin step2(1'b1, g2); g2 = nxt(g2); end
    tests_run++; if (locked2 !== 1'b1) begin tests_failed++; $display("FAIL sat_lock got=%b exp=1", locked2); end
    for (int i = 1; i <= 20; i++) begin
      step2(1'b1, g2 ^ 32'h0000_0100); g2 = nxt(g2);
      tests_run++;
      if (err_count2 !== ((i < 15) ? 4'(i) : 4'd15)) begin
        tests_failed++; $display("FAIL sat_count err=%0d got=%0d exp=%0d", i, err_count2, (i < 15) ? i : 15);
      end
    end
    tests_run++; if (locked2 !== 1'b1 || error2 !== 1'b1) begin tests_failed++; $display("FAIL sat_state got locked=%b error=%b exp 1/1", locked2, error2); end
  endtask

  task automatic test_random();
    int burst = 0;
    bit dv, clr;
    logic [31:0] d;
    do_reset();
    g = $urandom | 32'h1;
    for (int i = 0; i < 4000; i++) begin
      dv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      d   = g;
      if (dv) begin
        if (burst > 0) begin d = g ^ ($urandom | 32'h1); burst--; end
        else if ($urandom_range(0, 199) == 0) burst = $urandom_range(3, 6);
        else if ($urandom_range(0, 99) < 3) d = g ^ (32'h1 << $urandom_range(0, 31));
        else if ($urandom_range(0, 299) == 0) d = 32'd0;
        g = nxt(g);
      end else d = $urandom;
      step(dv, d, clr);
      tests_run++; if (locked !== m_locked) begin tests_failed++; $display("FAIL rand_locked cyc=%0d got=%b exp=%b", i, locked, m_locked); end
      tests_run++; if (error !== m_err) begin tests_failed++; $display("FAIL rand_error cyc=%0d got=%b exp=%b", i, error, m_err); end
      tests_run++; if (err_count !== m_cnt) begin tests_failed++; $display("FAIL rand_err_count cyc=%0d got=%0d exp=%0d", i, err_count, m_cnt); end
`ifdef LFSR_CHK_STATS_EN
      tests_run++; if (word_count !== m_words) begin tests_failed++; $display("FAIL rand_word_count cyc=%0d got=%0d exp=%0d", i, word_count, m_words); end
      tests_run++; if (lock_loss !== m_losses) begin tests_failed++; $display("FAIL rand_lock_loss cyc=%0d got=%0d exp=%0d", i, lock_loss, m_losses); end
`endif
    end
  endtask

  task automatic test_async_reset();
    clean(LOCK + 2);
    corrupt(32'h0000_0004);
    tests_run++; if (locked !== 1'b1 || err_count === '0) begin tests_failed++; $display("FAIL areset_pre got locked=%b cnt=%0d exp 1/nonzero", locked, err_count); end
    #3 reset_n = 1'b0;
    #1;
    tests_run++; if (locked !== 1'b0 || error !== 1'b0 || err_count !== '0) begin tests_failed++; $display("FAIL areset_immediate got locked=%b error=%b cnt=%0d exp 0/0/0", locked, error, err_count); end
    @(posedge clk); @(negedge clk); reset_n = 1'b1;
    model_reset();
    clean(LOCK);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL areset_relock_early got=%b exp=0", locked); end
    clean(1);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL areset_relock got=%b exp=1", locked); end
`ifdef LFSR_CHK_STATS_EN
    clean(100);
    tests_run++; if (word_count !== 48'd100) begin tests_failed++; $display("FAIL word_count got=%0d exp=100", word_count); end
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss();
    test_err_clear_collision();
    test_zero_words();
    test_gaps();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
